// File: rtl/dflop_delay_line.sv
// Clock-enabled, falling-edge delay line with a runtime-selectable tap.
// Each stage carries its sample plus a valid bit; a saturating fill counter reports when the tap holds real data.
module dflop_delay_line #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int DSEL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clken_i,
   input  logic              clr_i,
   input  logic [WIDTH-1:0]  in_i,
   input  logic              in_valid_i,
   input  logic [DSEL_W-1:0] dly_sel_i,
   output logic [WIDTH-1:0]  out_o,
   output logic              out_valid_o,
   output logic              primed_o,
   output logic [DSEL_W:0]   fill_o
);

   localparam logic [DSEL_W:0] LAST_TAP = (DSEL_W+1)'(DEPTH - 1);
   localparam logic [DSEL_W:0] FILL_MAX = (DSEL_W+1)'(DEPTH);
   localparam logic [DSEL_W:0] FILL_ONE = (DSEL_W+1)'(1);

   logic [WIDTH-1:0]  data_q  [DEPTH];
   logic [WIDTH-1:0]  data_d  [DEPTH];
   logic              valid_q [DEPTH];
   logic              valid_d [DEPTH];
   logic [DSEL_W:0]   fill_q;
   logic [DSEL_W:0]   fill_d;
   logic [DSEL_W-1:0] sel_eff_s;
   logic [WIDTH-1:0]  tap_data_s;
   logic              tap_valid_s;

   // Next-state: clear beats enable; a disabled edge holds everything.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      fill_d  = fill_q;
      if (clr_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_d[k]  = '0;
            valid_d[k] = 1'b0;
         end
         fill_d = '0;
      end else if (clken_i) begin
         data_d[0]  = in_i;
         valid_d[0] = in_valid_i;
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         fill_d = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FILL_ONE;
      end else begin
         fill_d = fill_q;
      end
   end

   // Stage and fill registers, falling-edge clocked with asynchronous reset.
   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k]  <= '0;
            valid_q[k] <= 1'b0;
         end
         fill_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         fill_q  <= fill_d;
      end
   end

   // Out-of-range selects clamp to the last stage rather than wrapping.
   always_comb begin
      if ({1'b0, dly_sel_i} > LAST_TAP) begin
         sel_eff_s = LAST_TAP[DSEL_W-1:0];
      end else begin
         sel_eff_s = dly_sel_i;
      end
   end

   // Tap mux; changing dly_sel_i is visible immediately, no flush.
   always_comb begin
      tap_data_s  = '0;
      tap_valid_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         tap_data_s  = (sel_eff_s == DSEL_W'(k)) ? data_q[k]  : tap_data_s;
         tap_valid_s = (sel_eff_s == DSEL_W'(k)) ? valid_q[k] : tap_valid_s;
      end
   end

   assign out_o       = tap_data_s;
   assign out_valid_o = tap_valid_s;
   assign primed_o    = (fill_q > {1'b0, sel_eff_s});
   assign fill_o      = fill_q;

endmodule

// File: tb/tb_dflop_delay_line.sv
// Directed bench for dflop_delay_line (DEPTH=16, DSEL_W=5 so out-of-range selects can be driven).
// Outputs are packed as {out, out_valid, primed, fill} and sampled 1 ns after each falling edge.
module tb_dflop_delay_line;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 16;
   localparam int DSEL_W = 5;

   logic              clk;
   logic              rst;
   logic              clken;
   logic              clr;
   logic [WIDTH-1:0]  din;
   logic              din_valid;
   logic [DSEL_W-1:0] sel;
   logic [WIDTH-1:0]  dout;
   logic              dout_valid;
   logic              primed;
   logic [DSEL_W:0]   fill;

   logic [15:0] obs_s;
   logic [15:0] exp_s;
   int          checks;
   int          passed;

   dflop_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DSEL_W(DSEL_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clken_i     (clken),
      .clr_i       (clr),
      .in_i        (din),
      .in_valid_i  (din_valid),
      .dly_sel_i   (sel),
      .out_o       (dout),
      .out_valid_o (dout_valid),
      .primed_o    (primed),
      .fill_o      (fill)
   );

   assign obs_s = {dout, dout_valid, primed, fill};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clk_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clken = 1'b1; clr = 1'b0; din = 8'h55; din_valid = 1'b1; sel = 5'd3;
      clk_edge();
      clk_edge();
      exp_s = 16'h0000;
      checks++;
      if (obs_s !== exp_s) $display("FAIL reset_held actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      rst = 1'b0;
      #1;
      checks++;
      if (obs_s !== exp_s) $display("FAIL reset_release actual=%h expected=%h", obs_s, exp_s);
      else passed++;
   endtask

   task automatic test_async_reset();
      do_reset();
      sel = 5'd3; clken = 1'b1; din_valid = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         din = 8'(n);
         clk_edge();
      end
      exp_s = {8'd3, 1'b1, 1'b1, 6'd6};
      checks++;
      if (obs_s !== exp_s) $display("FAIL midstream_pre actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      exp_s = 16'h0000;
      checks++;
      if (obs_s !== exp_s) $display("FAIL async_reset actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      clk_edge();
      checks++;
      if (obs_s !== exp_s) $display("FAIL reset_over_edge actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      do_reset();
      sel = 5'd3; clken = 1'b1; clr = 1'b0; din_valid = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         din = 8'(n);
         clk_edge();
         exp_s = {((n >= 4) ? 8'(n - 3) : 8'h00), (n >= 4), (n >= 4), 6'(n)};
         checks++;
         if (obs_s !== exp_s) $display("FAIL ramp n=%0d actual=%h expected=%h", n, obs_s, exp_s);
         else passed++;
      end
   endtask

   task automatic test_clken_toggle();
      int m;
      m = 0;
      do_reset();
      sel = 5'd3; clr = 1'b0; din_valid = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         clken = (e % 2 == 1);
         if (clken) begin
            m++;
            din = 8'(m);
         end else begin
            din = 8'hEE;
         end
         clk_edge();
         exp_s = {((m >= 4) ? 8'(m - 3) : 8'h00), (m >= 4), (m >= 4), 6'(m)};
         checks++;
         if (obs_s !== exp_s) $display("FAIL clken_toggle e=%0d actual=%h expected=%h", e, obs_s, exp_s);
         else passed++;
      end
   endtask

   task automatic test_clamp();
      do_reset();
      sel = 5'd20; clken = 1'b1; clr = 1'b0; din_valid = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         din = 8'(n);
         clk_edge();
         if (n == 15 || n == 16 || n == 17 || n == 40) begin
            exp_s = {((n >= 16) ? 8'(n - 15) : 8'h00), (n >= 16), (n >= 16),
                     ((n >= 16) ? 6'd16 : 6'(n))};
            checks++;
            if (obs_s !== exp_s) $display("FAIL clamp n=%0d actual=%h expected=%h", n, obs_s, exp_s);
            else passed++;
         end
      end
      sel = 5'd31;
      #1;
      exp_s = {8'd25, 1'b1, 1'b1, 6'd16};
      checks++;
      if (obs_s !== exp_s) $display("FAIL clamp_sel31 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
   endtask

   task automatic test_clr_drop();
      do_reset();
      sel = 5'd2; clken = 1'b1; clr = 1'b0; din_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         din = 8'h10 + 8'(j);
         clk_edge();
      end
      exp_s = {8'h12, 1'b1, 1'b1, 6'd5};
      checks++;
      if (obs_s !== exp_s) $display("FAIL clr_pre actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      clr = 1'b1; din = 8'hAA;
      clk_edge();
      clr = 1'b0;
      exp_s = 16'h0000;
      checks++;
      if (obs_s !== exp_s) $display("FAIL clr_with_clken actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      // Sample 2 of the refill carries in_valid=0 and must emerge unqualified.
      for (int j = 1; j <= 6; j++) begin
         din = 8'h50 + 8'(j);
         din_valid = (j != 2);
         clk_edge();
         exp_s = {((j >= 3) ? 8'h50 + 8'(j - 2) : 8'h00), ((j >= 3) && (j != 4)), (j >= 3), 6'(j)};
         checks++;
         if (obs_s !== exp_s) $display("FAIL clr_refill j=%0d actual=%h expected=%h", j, obs_s, exp_s);
         else passed++;
      end
      din_valid = 1'b1; clken = 1'b0; clr = 1'b1;
      clk_edge();
      clr = 1'b0;
      exp_s = 16'h0000;
      checks++;
      if (obs_s !== exp_s) $display("FAIL clr_no_clken actual=%h expected=%h", obs_s, exp_s);
      else passed++;
   endtask

   task automatic test_sel_switch();
      do_reset();
      sel = 5'd5; clken = 1'b1; clr = 1'b0; din_valid = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         din = 8'(n);
         clk_edge();
      end
      exp_s = {8'd5, 1'b1, 1'b1, 6'd10};
      checks++;
      if (obs_s !== exp_s) $display("FAIL sel5 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      sel = 5'd2;
      #1;
      exp_s = {8'd8, 1'b1, 1'b1, 6'd10};
      checks++;
      if (obs_s !== exp_s) $display("FAIL sel_to_2 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      clr = 1'b1;
      clk_edge();
      clr = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         din = 8'h20 + 8'(n);
         clk_edge();
      end
      clken = 1'b0;
      sel = 5'd9;
      #1;
      exp_s = {8'h00, 1'b0, 1'b0, 6'd7};
      checks++;
      if (obs_s !== exp_s) $display("FAIL sel_to_9 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      sel = 5'd6;
      #1;
      exp_s = {8'h21, 1'b1, 1'b1, 6'd7};
      checks++;
      if (obs_s !== exp_s) $display("FAIL sel_to_6 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
      sel = 5'd7;
      #1;
      exp_s = {8'h00, 1'b0, 1'b0, 6'd7};
      checks++;
      if (obs_s !== exp_s) $display("FAIL sel_to_7 actual=%h expected=%h", obs_s, exp_s);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_async_reset();
      test_ramp();
      test_clken_toggle();
      test_clamp();
      test_clr_drop();
      test_sel_switch();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
